// File: rtl/ram_port_arbiter.sv
// Two-port req/ack arbiter and sequencer for a single-port big-endian data RAM.
// Optional macro ARB_FIXED_PRIO_EN: fixed A-over-B priority instead of round-robin.
//
// state  | meaning
// IDLE   | waiting for a request, arbitrates and latches the winner
// ACCESS | one RAM cycle (read, falling-edge write, or nothing on range error)
// ACK    | owner's ack/err pulse, RAM controls idle
module ram_port_arbiter #(
  parameter int unsigned RAM_BYTES = 61
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        we_a,
  input  logic        we_b,
  input  logic [31:0] addr_a,
  input  logic [31:0] addr_b,
  input  logic [31:0] wdata_a,
  input  logic [31:0] wdata_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic        err_a,
  output logic        err_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic        busy,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_nRD,
  output logic        ram_nWR,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [32:0] LAST_VALID = 33'(RAM_BYTES - 4);

  state_t      state, state_nxt;
  logic        start;
  logic        grant_b;
  logic        owner_b;
  logic        lat_we;
  logic        lat_err;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;
  logic        sel_err;
`ifndef ARB_FIXED_PRIO_EN
  logic        last_grant_b;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          start     = 1'b1;
          state_nxt = ACCESS;
          if (req_a && req_b) begin
`ifdef ARB_FIXED_PRIO_EN
            grant_b = 1'b0;
`else
            grant_b = ~last_grant_b;
`endif
          end else begin
            grant_b = req_b;
          end
        end
      end
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // 33-bit compare so addresses near 2^32 cannot wrap into range
  assign sel_addr  = grant_b ? addr_b  : addr_a;
  assign sel_wdata = grant_b ? wdata_b : wdata_a;
  assign sel_we    = grant_b ? we_b    : we_a;
  assign sel_err   = {1'b0, sel_addr} > LAST_VALID;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_b      <= 1'b0;
      lat_we       <= 1'b0;
      lat_err      <= 1'b0;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      err_a        <= 1'b0;
      err_b        <= 1'b0;
      rdata_a      <= '0;
      rdata_b      <= '0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_nRD      <= 1'b0;
      ram_nWR      <= 1'b1;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_b <= 1'b1;
`endif
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      err_a <= 1'b0;
      err_b <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            owner_b      <= grant_b;
            lat_we       <= sel_we;
            lat_err      <= sel_err;
            ram_addr     <= sel_addr;
            ram_wdata    <= sel_wdata;
            ram_nRD      <= ~sel_err & ~sel_we;
            ram_nWR      <= ~(~sel_err & sel_we);
`ifndef ARB_FIXED_PRIO_EN
            last_grant_b <= grant_b;
`endif
          end
        end
        ACCESS: begin
          ram_nRD <= 1'b0;
          ram_nWR <= 1'b1;
          if (owner_b) begin
            ack_b <= 1'b1;
            err_b <= lat_err;
            if (lat_err)     rdata_b <= '0;
            else if (!lat_we) rdata_b <= ram_rdata;
          end else begin
            ack_a <= 1'b1;
            err_a <= lat_err;
            if (lat_err)     rdata_a <= '0;
            else if (!lat_we) rdata_a <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the single-port, byte-addressed, big-endian data RAM (combinational read gated by `nRD`, write on falling clock edge gated by `nWR`). Port A serves the CPU data path and port B serves the loader/debug master. Each port uses a req/ack handshake. The block drives one RAM transaction at a time, captures read data, and flags out-of-range addresses without touching the RAM.

## Interface
Parameters:
- `RAM_BYTES`, 61: RAM size in bytes. An access is valid iff `addr + 3 <= RAM_BYTES - 1`.

Ports:
- `clk`  in  1  system clock. State updates on the rising edge; the RAM writes on the falling edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_a` / `req_b`  in  1  request. Held high until the port's ack.
- `we_a` / `we_b`  in  1  1 = word write, 0 = word read.
- `addr_a` / `addr_b`  in  32  byte address of the word's MSB byte.
- `wdata_a` / `wdata_b`  in  32  write data, `[31:24]` at `addr`.
- `ack_a` / `ack_b`  out  1  one-cycle completion pulse.
- `err_a` / `err_b`  out  1  high with ack when the address was out of range.
- `rdata_a` / `rdata_b`  out  32  read result. Valid with ack; holds until that port's next ack.
- `busy`  out  1  high whenever the state is not IDLE.
- `ram_addr`  out  32  RAM address.
- `ram_wdata`  out  32  RAM write data.
- `ram_nRD`  out  1  1 = RAM drives read data, 0 = RAM output is high-Z.
- `ram_nWR`  out  1  0 = write on the next falling edge, 1 = no write.
- `ram_rdata`  in  32  RAM read data.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- **IDLE**
  - With no request, stay in IDLE.
  - With any request, pick the winner.
  - Latch owner, `we`, `addr` and `wdata` into internal registers.
  - Evaluate range: `addr > RAM_BYTES-4`, computed in 33 bits so no wrap.
  - Go to ACCESS.
- **ACCESS** (exactly one cycle)
  - In range, read: `ram_addr` = latched addr, `ram_nRD=1`, `ram_nWR=1`.
  - In range, write: `ram_addr` and `ram_wdata` latched, `ram_nRD=0`, `ram_nWR=0`. The RAM commits on the falling edge inside this cycle.
  - Out of range: `ram_nRD=0`, `ram_nWR=1`; the RAM is untouched.
  - On exit, the owner's `rdata` is loaded:
    - `ram_rdata` for an in-range read;
    - 0 for an error;
    - unchanged for a write.
  - Go to ACK.
- **ACK** (one cycle)
  - Owner's `ack` is high; `err` is high if out of range.
  - RAM controls return to idle: `ram_nRD=0`, `ram_nWR=1`.
  - Requests are not sampled.
  - Go to IDLE.
- **Arbitration**: round-robin on `last_grant`.
  - On simultaneous requests, the port not granted last wins.
  - `last_grant` resets to B, so A wins the first tie.
  - A lone requester always wins.
- **Requester rules**
  - Inputs must stay stable from req rise through ack.
  - The requester must drop req by the rising edge that ends its ACK cycle. If req is still high in the following IDLE cycle, it is a new request.
- The non-owner's `req` stays pending, with no ack, until it is granted.

## Timing
- **Reset values**:
  - state IDLE, `last_grant` = B;
  - `ack_*` = 0, `err_*` = 0, `rdata_*` = 0, `busy` = 0;
  - `ram_addr` = 0, `ram_wdata` = 0, `ram_nRD` = 0, `ram_nWR` = 1.
- **Latency**: req sampled at rising edge N; ACCESS occupies cycle N..N+1; ack is high in cycle N+1..N+2.
  - Back-to-back throughput: one transaction per 3 cycles.
- All RAM control outputs and `ack`/`err`/`rdata` are registered; there are no combinational paths from request inputs to outputs.
- `ram_nWR` changes only on rising edges, so it is stable across the falling write edge.
- **Reset mid-ACCESS**: outputs go to reset values asynchronously.
  - Reset asserted before the falling edge: the write is suppressed.
  - No ack is issued for the aborted transaction; the requester re-requests after reset.
- A request arriving during ACCESS or ACK waits and is arbitrated in the next IDLE cycle.

## Configuration
- `ARB_FIXED_PRIO_EN` defined: fixed priority, A always beats B on simultaneous requests. `last_grant` is neither used nor updated.
- Undefined (default): round-robin as above.

## Test plan
- **Reset**: `reset=1` mid-ACCESS of a write (A, addr 8, data 0xDEADBEEF) before the falling edge -> `ram_nWR=1` immediately, no ack, and a later read of addr 8 returns the pre-reset contents.
- **Single write then read**: A writes 0x11223344 at addr 4 -> `ack_a` 2 cycles after sample. A then reads addr 4 -> `rdata_a`=0x11223344, and RAM bytes 4..7 = 0x11, 0x22, 0x33, 0x44.
- **Tie after reset**: `req_a` and `req_b` rise together (A reads 0, B reads 4).
  - Round-robin build: A acked first, then B acked 3 cycles later.
  - With `ARB_FIXED_PRIO_EN`, A also wins the next tie.
- **Out of range**: B reads addr 58 (`RAM_BYTES`=61) -> `ack_b` with `err_b=1`, `rdata_b`=0, and `ram_nRD`/`ram_nWR` never active.
- **Held req**: A keeps req high past ack -> a second transaction starts in the following IDLE cycle, with ack again 3 cycles later.
- **Starvation check**: A requests continuously while B holds req -> round-robin grants alternate A, B, A, B and `ack_b` arrives within 6 cycles.
